fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage directly downstream of the branch-target/predictor block. It owns the fetch PC register (`fpc`), which it drives back to the predictor. Each cycle it consumes the predictor's `next_pc`/`pred`, reads the instruction memory combinationally at `fpc`, and fills the IF/ID pipeline register with PC, instruction and prediction metadata. It also applies stalls from the hazard unit and execute-stage mispredict redirects, and holds fetch in a short boot phase after reset.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `BOOT_CYCLES`, default 2: cycles fetch is held after reset release; legal range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `next_pc`  in  32  predicted next fetch address from the predictor.
- `pred`  in  1  predictor taken bit for `fpc`.
- `stall`  in  1  hazard unit: hold `fpc` and the IF/ID register.
- `redirect_valid`  in  1  execute-stage mispredict or resolved-branch correction.
- `redirect_pc`  in  32  corrected fetch address.
- `imem_rdata`  in  32  instruction at `fpc`, combinational read.
- `fpc`  out  32  current fetch PC; goes to imem address and predictor.
- `id_valid`  out  1  IF/ID register holds a real instruction.
- `id_pc`  out  32  PC of the IF/ID instruction.
- `id_instr`  out  32  instruction word.
- `id_pred`  out  1  a taken prediction was applied to this instruction.
- `id_pred_target`  out  32  address fetched after this instruction.

## Operation
- FSM states: BOOT and RUN.
- Reset:
  - state=BOOT, boot counter=0, `fpc`=RESET_PC.
  - `id_valid`=0; `id_pc`, `id_instr` and `id_pred_target` = 0; `id_pred`=0.
- BOOT:
  - Counter increments each cycle. `fpc` holds RESET_PC and `id_valid` stays 0.
  - `stall` and `redirect_valid` are ignored.
  - On the cycle the counter reaches BOOT_CYCLES-1, state becomes RUN at the next edge.
- RUN, priority redirect > stall > advance:
  - Redirect: `fpc` <= {`redirect_pc`[31:2], 2'b00}. `id_valid` <= 0 (flushes the wrong-path instruction). Other id_* fields hold.
  - Stall: all registers hold, including `id_valid`.
  - Advance: `fpc` <= `next_pc` and `id_valid` <= 1. `id_pc` <= `fpc`, `id_instr` <= `imem_rdata`, `id_pred_target` <= `next_pc`.
  - Advance, prediction bit: `id_pred` <= `pred` & (`next_pc` != `fpc`+4).
- PC arithmetic is 32-bit modulo. `fpc`+4 at 32'hFFFF_FFFC wraps to 0 with no error.
- Redirect on the same cycle as stall: the redirect wins. The flushed slot is invalid, so the stall does not preserve wrong-path data.
- Redirect to the current `fpc` is still a redirect: one bubble is inserted.
- Async reset mid-operation returns to BOOT immediately, with the reset values above.

## Timing
- `fpc` is registered. `imem_rdata` is sampled in the same cycle `fpc` is presented.
- Fetch-to-IF/ID latency is 1 cycle.
- The first `id_valid`=1 appears BOOT_CYCLES+1 edges after reset release, with `id_pc`=RESET_PC.
- Redirect penalty: redirect asserted at edge N gives `fpc`=target after N. `id_valid`=0 after N; target instruction is valid in IF/ID after N+1.
- `stall` is a level signal: each stalled cycle freezes the stage for exactly one cycle.
- Outputs depend only on registers. No combinational input-to-output path exists, except that `fpc` feeds the external imem/predictor loop.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `perf_redirects[31:0]` and `perf_stalls[31:0]`, both reset to 0.
  - `perf_redirects` increments on each RUN-state redirect.
  - `perf_stalls` increments on each RUN-state cycle with `stall`=1 and `redirect_valid`=0.
  - Both counters wrap at 2^32.
- `FETCH_PERF_CNT_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset release with RESET_PC=0, BOOT_CYCLES=2, `next_pc`=`fpc`+4:
  - `id_valid` rises on the 3rd edge with `id_pc`=0.
  - `id_pc` then follows 4, 8, 12.
- Predicted taken: `fpc`=40, `pred`=1, `next_pc`=56 → next `fpc`=56; IF/ID shows `id_pc`=40, `id_pred`=1, `id_pred_target`=56.
- `pred`=1 with `next_pc`=`fpc`+4 → `id_pred`=0.
- `stall` high 3 cycles at `fpc`=20 → `fpc`, `id_pc` and `id_instr` unchanged for 3 cycles; advance resumes on the 4th.
- `redirect_valid`=1, `redirect_pc`=32'h0000_0103 together with `stall`=1 → `fpc`=32'h100 and `id_valid`=0 next cycle; valid `id_pc`=32'h100 one cycle later.
- `rstn` pulsed low mid-run at `fpc`=64 → `fpc`=RESET_PC and `id_valid`=0 immediately; BOOT repeats. With `FETCH_PERF_CNT_EN`, both counters read 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: predictor, hazard/redirect, imem read and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the perf counter signals.
interface fetch_stage_if;
  logic [31:0] next_pc;
  logic        pred;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic [31:0] fpc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_pred;
  logic [31:0] id_pred_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stalls;
`endif

  // master: the fetch stage itself
  modport master (
    input  next_pc, pred, stall, redirect_valid, redirect_pc, imem_rdata,
    output fpc, id_valid, id_pc, id_instr, id_pred, id_pred_target
`ifdef FETCH_PERF_CNT_EN
    , output perf_redirects, perf_stalls
`endif
  );

  modport slave (
    output next_pc, pred, stall, redirect_valid, redirect_pc, imem_rdata,
    input  fpc, id_valid, id_pc, id_instr, id_pred, id_pred_target
`ifdef FETCH_PERF_CNT_EN
    , input perf_redirects, perf_stalls
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns fpc, fills IF/ID, applies stall/redirect, boot hold.
// Optional FETCH_PERF_CNT_EN adds redirect/stall performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input logic             clk,
  input logic             rstn,
  fetch_stage_if.master   bus
);

  localparam logic [7:0] BootLast = 8'(BOOT_CYCLES - 1);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic        do_redirect, do_stall, do_advance;

  logic [31:0] fpc_q;
  logic        id_valid_q;
  logic [31:0] id_pc_q, id_instr_q, id_pred_target_q;
  logic        id_pred_q;
  logic [31:0] seq_pc;

  assign seq_pc = fpc_q + 32'd4;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StBoot;
      boot_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      StBoot: begin
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BootLast) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // Redirect outranks stall; nothing happens outside RUN.
  always_comb begin
    do_redirect = 1'b0;
    do_stall    = 1'b0;
    do_advance  = 1'b0;
    case (state_q)
      StRun: begin
        do_redirect = bus.redirect_valid;
        do_stall    = !bus.redirect_valid && bus.stall;
        do_advance  = !bus.redirect_valid && !bus.stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpc_q            <= RESET_PC;
      id_valid_q       <= 1'b0;
      id_pc_q          <= 32'd0;
      id_instr_q       <= 32'd0;
      id_pred_q        <= 1'b0;
      id_pred_target_q <= 32'd0;
    end else if (do_redirect) begin
      fpc_q      <= {bus.redirect_pc[31:2], 2'b00};
      id_valid_q <= 1'b0;
    end else if (do_advance) begin
      fpc_q            <= bus.next_pc;
      id_valid_q       <= 1'b1;
      id_pc_q          <= fpc_q;
      id_instr_q       <= bus.imem_rdata;
      id_pred_target_q <= bus.next_pc;
      // A "taken" prediction that lands on the fall-through is not a real redirect.
      id_pred_q        <= bus.pred && (bus.next_pc != seq_pc);
    end
  end

  assign bus.fpc            = fpc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_instr       = id_instr_q;
  assign bus.id_pred        = id_pred_q;
  assign bus.id_pred_target = id_pred_target_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_stalls_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_redirects_q <= 32'd0;
      perf_stalls_q    <= 32'd0;
    end else begin
      if (do_redirect) perf_redirects_q <= perf_redirects_q + 32'd1;
      if (do_stall)    perf_stalls_q    <= perf_stalls_q + 32'd1;
    end
  end

  assign bus.perf_redirects = perf_redirects_q;
  assign bus.perf_stalls    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage against a cycle-level behavioural model,
// with directed scenarios pinning boot, prediction, stall, redirect and reset.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned BOOT_CYCLES = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign bus.imem_rdata = imem_f(bus.fpc);

  // Model state
  int          boot_left;
  logic [31:0] m_fpc, m_id_pc, m_instr, m_tgt;
  logic        m_valid, m_pred;
  logic [31:0] m_redirs, m_stalls;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    boot_left = BOOT_CYCLES;
    m_fpc     = RESET_PC;
    m_id_pc   = '0;
    m_instr   = '0;
    m_tgt     = '0;
    m_valid   = 1'b0;
    m_pred    = 1'b0;
    m_redirs  = '0;
    m_stalls  = '0;
  endtask

  task automatic model_step();
    if (!rstn) return;
    if (boot_left > 0) begin
      boot_left--;
    end else if (bus.redirect_valid) begin
      m_fpc   = bus.redirect_pc & ~32'd3;
      m_valid = 1'b0;
      m_redirs++;
    end else if (bus.stall) begin
      m_stalls++;
    end else begin
      m_id_pc = m_fpc;
      m_instr = imem_f(m_fpc);
      m_tgt   = bus.next_pc;
      m_pred  = bus.pred && (bus.next_pc != m_fpc + 32'd4);
      m_fpc   = bus.next_pc;
      m_valid = 1'b1;
    end
  endtask

  // One clock: update model at the edge, return 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("fpc", bus.fpc, m_fpc);
      chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
      chk("id_pc", bus.id_pc, m_id_pc);
      chk("id_instr", bus.id_instr, m_instr);
      chk("id_pred", 32'(bus.id_pred), 32'(m_pred));
      chk("id_pred_target", bus.id_pred_target, m_tgt);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_redirects", bus.perf_redirects, m_redirs);
      chk("perf_stalls", bus.perf_stalls, m_stalls);
`endif
    end
  end

  task automatic drive(input logic [31:0] np, input logic pr, input logic st,
                       input logic rv, input logic [31:0] rp);
    bus.next_pc        = np;
    bus.pred           = pr;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
  endtask

  task automatic seq();
    drive(m_fpc + 32'd4, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic boot_checks();
    seq(); cycle(); chk("boot1_valid", 32'(bus.id_valid), 32'd0);
    seq(); cycle(); chk("boot2_valid", 32'(bus.id_valid), 32'd0);
    seq(); cycle(); chk("boot3_valid", 32'(bus.id_valid), 32'd1);
    chk("boot3_pc", bus.id_pc, 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    drive(32'd0, 1'b0, 1'b0, 1'b1, a);
    cycle();
  endtask

  initial begin
    drive(32'd4, 1'b0, 1'b0, 1'b0, 32'd0);
    model_reset();
    cmp_en = 1'b1;
    #1;
    chk("rst_fpc", bus.fpc, RESET_PC);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    cycle();
    cycle();
    rstn = 1'b1;

    boot_checks();
    for (int i = 1; i <= 3; i++) begin
      seq(); cycle();
      chk("seq_pc", bus.id_pc, 32'(4 * i));
    end

    redirect_to(32'd40);
    chk("redir40_fpc", bus.fpc, 32'd40);
    chk("redir40_valid", 32'(bus.id_valid), 32'd0);
    drive(32'd56, 1'b1, 1'b0, 1'b0, 32'd0); cycle();
    chk("taken_fpc", bus.fpc, 32'd56);
    chk("taken_id_pc", bus.id_pc, 32'd40);
    chk("taken_id_pred", 32'(bus.id_pred), 32'd1);
    chk("taken_target", bus.id_pred_target, 32'd56);
    drive(32'd60, 1'b1, 1'b0, 1'b0, 32'd0); cycle();
    chk("fallthru_pred", 32'(bus.id_pred), 32'd0);
    chk("fallthru_id_pc", bus.id_pc, 32'd56);

    redirect_to(32'd16);
    drive(32'd20, 1'b0, 1'b0, 1'b0, 32'd0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(32'd24, 1'b0, 1'b1, 1'b0, 32'd0); cycle();
      chk("stall_fpc", bus.fpc, 32'd20);
      chk("stall_id_pc", bus.id_pc, 32'd16);
      chk("stall_instr", bus.id_instr, imem_f(32'd16));
    end
    drive(32'd24, 1'b0, 1'b0, 1'b0, 32'd0); cycle();
    chk("resume_fpc", bus.fpc, 32'd24);
    chk("resume_id_pc", bus.id_pc, 32'd20);

    drive(32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0103); cycle();
    chk("rs_fpc", bus.fpc, 32'h100);
    chk("rs_valid", 32'(bus.id_valid), 32'd0);
    drive(32'h104, 1'b0, 1'b0, 1'b0, 32'd0); cycle();
    chk("rs_id_valid", 32'(bus.id_valid), 32'd1);
    chk("rs_id_pc", bus.id_pc, 32'h100);

    redirect_to(32'hFFFF_FFFC);
    drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0); cycle();
    chk("wrap_fpc", bus.fpc, 32'd0);

    redirect_to(32'd64);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("midrst_fpc", bus.fpc, RESET_PC);
    chk("midrst_valid", 32'(bus.id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_predir", bus.perf_redirects, 32'd0);
    chk("midrst_pstall", bus.perf_stalls, 32'd0);
`endif
    cycle();
    rstn = 1'b1;
    boot_checks();

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] np, rp;
      int unsigned r;
      r  = $urandom_range(0, 99);
      np = (r < 70) ? m_fpc + 32'd4 : ($urandom() & ~32'd3);
      rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      drive(np, 1'($urandom()), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10), rp);
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0;
        model_reset();
        cycle();
        rstn = 1'b1;
      end else begin
        cycle();
      end
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
